// File: rtl/audio_level_meter.sv
// audio_level_meter: windowed peak-magnitude meter driving an LED bar graph
// and a single active-low 7-segment digit (level+1).
// Optional feature: define PEAK_HOLD_EN for a decaying peak-hold LED marker.
module audio_level_meter #(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned MID         = 2048,
  parameter int unsigned WINDOW      = 4000,
  parameter int unsigned NUM_LEVELS  = 9,
  parameter int unsigned STEP        = 227,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic                  basys_clock,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     sample,
  input  logic                  sample_valid,
  output logic [3:0]            level,
  output logic                  level_valid,
  output logic [NUM_LEVELS-1:0] led,
  output logic [6:0]            seg,
  output logic [3:0]            an
);
  localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int unsigned THR_W = DATA_W + 4;
  localparam logic [DATA_W-1:0] MID_C = DATA_W'(MID);
  localparam logic [6:0] SEG_ONE = 7'b1111001;

  typedef enum logic [1:0] {S_IDLE, S_QUANT, S_PUBLISH} state_t;

  // Digit code for level+1, active-low gfedcba.
  function automatic logic [6:0] seg_of(input logic [3:0] l);
    case (l)
      4'd0:    seg_of = 7'b1111001;
      4'd1:    seg_of = 7'b0100100;
      4'd2:    seg_of = 7'b0110000;
      4'd3:    seg_of = 7'b0011001;
      4'd4:    seg_of = 7'b0010010;
      4'd5:    seg_of = 7'b0000010;
      4'd6:    seg_of = 7'b1111000;
      4'd7:    seg_of = 7'b0000000;
      4'd8:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Bar graph with bits [l:0] lit.
  function automatic logic [NUM_LEVELS-1:0] bar_of(input logic [3:0] l);
    logic [NUM_LEVELS-1:0] b;
    for (int unsigned i = 0; i < NUM_LEVELS; i++) b[i] = (i <= {28'd0, l});
    return b;
  endfunction

  // ---------------- windowed peak accumulator ----------------
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] peak_q, peak_d, snap_q, snap_d;
  logic              win_done_q, win_done_d;
  logic [DATA_W-1:0] mag, pk_max;

  assign mag    = (sample >= MID_C) ? (sample - MID_C) : (MID_C - sample);
  assign pk_max = (mag > peak_q) ? mag : peak_q;

  // Next-state for the accumulator; the last sample of a window lands in the snapshot.
  always_comb begin
    cnt_d      = cnt_q;
    peak_d     = peak_q;
    snap_d     = snap_q;
    win_done_d = 1'b0;
    if (sample_valid) begin
      if (cnt_q == CNT_W'(WINDOW - 1)) begin
        snap_d     = pk_max;
        peak_d     = '0;
        cnt_d      = '0;
        win_done_d = 1'b1;
      end else begin
        peak_d = pk_max;
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  // Accumulator registers.
  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      peak_q     <= '0;
      snap_q     <= '0;
      win_done_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      peak_q     <= peak_d;
      snap_q     <= snap_d;
      win_done_q <= win_done_d;
    end
  end

  // ---------------- sequential quantiser FSM ----------------
  state_t                state_q, state_d;
  logic [3:0]            k_q, k_d, lvl_acc_q, lvl_acc_d, level_q, level_d;
  logic [THR_W-1:0]      thr_q, thr_d;
  logic                  level_valid_q, level_valid_d;
  logic [NUM_LEVELS-1:0] bar_q, bar_d;
  logic [6:0]            seg_q, seg_d;

  // One threshold compare per QUANT cycle; threshold grows by STEP each cycle.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    thr_d         = thr_q;
    lvl_acc_d     = lvl_acc_q;
    level_d       = level_q;
    level_valid_d = 1'b0;
    bar_d         = bar_q;
    seg_d         = seg_q;
    case (state_q)
      S_IDLE: begin
        if (win_done_q) begin
          state_d   = S_QUANT;
          k_d       = 4'd1;
          thr_d     = THR_W'(STEP);
          lvl_acc_d = '0;
        end
      end
      S_QUANT: begin
        if ({{(THR_W-DATA_W){1'b0}}, snap_q} >= thr_q) lvl_acc_d = lvl_acc_q + 1'b1;
        thr_d = thr_q + THR_W'(STEP);
        k_d   = k_q + 1'b1;
        if (k_q == 4'(NUM_LEVELS - 1)) state_d = S_PUBLISH;
      end
      S_PUBLISH: begin
        level_d       = lvl_acc_q;
        level_valid_d = 1'b1;
        bar_d         = bar_of(lvl_acc_q);
        seg_d         = seg_of(lvl_acc_q);
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      k_q           <= '0;
      thr_q         <= '0;
      lvl_acc_q     <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
      bar_q         <= NUM_LEVELS'(1);
      seg_q         <= SEG_ONE;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      thr_q         <= thr_d;
      lvl_acc_q     <= lvl_acc_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      bar_q         <= bar_d;
      seg_q         <= seg_d;
    end
  end

  assign level       = level_q;
  assign level_valid = level_valid_q;
  assign seg         = seg_q;
  assign an          = 4'b1110;

`ifdef PEAK_HOLD_EN
  localparam int unsigned TMR_W = $clog2(HOLD_CYCLES + 1);
  logic [3:0]       hold_q, hold_d, cur_lvl;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Hold marker: raised by a publish at/above it, otherwise decays one band per
  // HOLD_CYCLES. Expiry is taken at count 1 so that a reload of HOLD_CYCLES
  // yields a dwell of exactly HOLD_CYCLES edges.
  always_comb begin
    hold_d  = hold_q;
    tmr_d   = tmr_q;
    cur_lvl = (state_q == S_PUBLISH) ? lvl_acc_q : level_q;
    if (state_q == S_PUBLISH && lvl_acc_q >= hold_q) begin
      hold_d = lvl_acc_q;
      tmr_d  = TMR_W'(HOLD_CYCLES);
    end else if (tmr_q <= TMR_W'(1)) begin
      if (hold_q > cur_lvl) hold_d = hold_q - 1'b1;
      tmr_d = TMR_W'(HOLD_CYCLES);
    end else begin
      tmr_d = tmr_q - 1'b1;
    end
  end

  // Hold register and dwell timer.
  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      tmr_q  <= '0;
    end else begin
      hold_q <= hold_d;
      tmr_q  <= tmr_d;
    end
  end

  assign led = bar_q | (NUM_LEVELS'(1) << hold_q);
`else
  assign led = bar_q;
`endif

endmodule
